// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle digit-serial adder for wide operands.
// Adds DIGIT bits per clock over NDIG = WIDTH/DIGIT cycles, with a carry register
// between digits, behind a start/busy/done handshake.
// WIDTH must be a multiple of DIGIT.
// Optional feature macro: DSA_SUB_EN adds the 'sub' port (a-b, co = no-borrow).
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef DSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_eff;
    logic             carry_init;
    logic [DIGIT:0]   dsum;

    // Operand conditioning at accept time: subtract stores ~b and forces carry-in to 1
    always_comb begin
        b_eff      = b;
        carry_init = ci;
`ifdef DSA_SUB_EN
        if (sub) begin
            b_eff      = ~b;
            carry_init = 1'b1;
        end
`endif
    end

    // Next-state and datapath: one DIGIT-wide ripple slice per RUN cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        done_d  = 1'b0;

        dsum = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]}
             + {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
             + {{DIGIT{1'b0}}, carry_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = carry_init;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    co_d    = dsum[DIGIT];
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule
